// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// Latency: none; this file only groups signals.
// Backpressure: none; start is ignored while the adder reports busy.
//
// Ports carried (master = requester, slave = adder):
//   start, a, b, cin   master -> slave   request and operands
//   busy, done         slave  -> master  status (never high together)
//   sum, cout, ovf     slave  -> master  result, valid on done, held afterwards
interface serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: sum = a + b + cin, DIGIT bits per clock, with carry-out and signed overflow.
// Latency: N+1 clocks from accepted start to done, where N = WIDTH/DIGIT.
// Backpressure: start is taken only in IDLE or DONE; a start seen while busy is dropped.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any operation in flight
//   io    serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout/ovf out
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  io
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Catch bad parameter combinations at elaboration.
   if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0 (WIDTH=%0d DIGIT=%0d)",
             WIDTH, DIGIT);
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_d;

   // Operand shift registers: the low DIGIT bits are consumed each RUN cycle.
   logic [WIDTH-1:0] opa, opb;
   // Partial sum, filled from the MSB end so it is aligned after N shifts.
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   // Operand sign bits kept aside because the shift registers lose them.
   logic             sa, sb;

   // Visible result registers; only written on the final RUN edge.
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             accept;
   logic             last;
   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] dext;
   logic [WIDTH-1:0] acc_next;

   // ------------------------------------------------------------------
   // Digit slice and accumulator update
   // ------------------------------------------------------------------
   always_comb begin
      dsum     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      dext     = WIDTH'(dsum[DIGIT-1:0]);
      // Shift-based form stays legal when DIGIT == WIDTH (no zero-width slices).
      acc_next = (acc >> DIGIT) | (dext << (WIDTH - DIGIT));
   end

   assign last   = (state == S_RUN) && (cnt == CW'(N - 1));
   // DONE accepts start exactly like IDLE so back-to-back ops have no bubble.
   assign accept = io.start && ((state == S_IDLE) || (state == S_DONE));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (io.start) state_d = S_RUN;
         S_RUN:   if (last)     state_d = S_DONE;
         S_DONE:  state_d = io.start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      io.busy = (state == S_RUN);
      io.done = (state == S_DONE);
      io.sum  = sum_q;
      io.cout = cout_q;
      io.ovf  = ovf_q;
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         opa   <= io.a;
         opb   <= io.b;
         carry <= io.cin;
         sa    <= io.a[WIDTH-1];
         sb    <= io.b[WIDTH-1];
         acc   <= '0;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         opa   <= opa >> DIGIT;
         opb   <= opb >> DIGIT;
         acc   <= acc_next;
         carry <= dsum[DIGIT];
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum_q  <= acc_next;
            cout_q <= dsum[DIGIT];
            // Signed overflow: like-signed operands producing an opposite-signed sum.
            ovf_q  <= (sa == sb) && (acc_next[WIDTH-1] != sa);
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder across several WIDTH/DIGIT configurations.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercised by starting mid-RUN and in the DONE cycle.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8))  i8d1 ();
   serial_adder_if #(.WIDTH(8))  i8d2 ();
   serial_adder_if #(.WIDTH(1))  i1d1 ();
   serial_adder_if #(.WIDTH(16)) i16d1 ();
   serial_adder_if #(.WIDTH(16)) i16d2 ();
   serial_adder_if #(.WIDTH(16)) i16d4 ();
   serial_adder_if #(.WIDTH(16)) i16d8 ();
   serial_adder_if #(.WIDTH(16)) i16d16 ();

   serial_adder #(.WIDTH(8),  .DIGIT(1))  u8d1   (.clk(clk), .rst(rst), .io(i8d1.slave));
   serial_adder #(.WIDTH(8),  .DIGIT(2))  u8d2   (.clk(clk), .rst(rst), .io(i8d2.slave));
   serial_adder #(.WIDTH(1),  .DIGIT(1))  u1d1   (.clk(clk), .rst(rst), .io(i1d1.slave));
   serial_adder #(.WIDTH(16), .DIGIT(1))  u16d1  (.clk(clk), .rst(rst), .io(i16d1.slave));
   serial_adder #(.WIDTH(16), .DIGIT(2))  u16d2  (.clk(clk), .rst(rst), .io(i16d2.slave));
   serial_adder #(.WIDTH(16), .DIGIT(4))  u16d4  (.clk(clk), .rst(rst), .io(i16d4.slave));
   serial_adder #(.WIDTH(16), .DIGIT(8))  u16d8  (.clk(clk), .rst(rst), .io(i16d8.slave));
   serial_adder #(.WIDTH(16), .DIGIT(16)) u16d16 (.clk(clk), .rst(rst), .io(i16d16.slave));

   // All 16-bit instances see the same request so one stimulus checks every DIGIT.
   logic        s16_start;
   logic [15:0] s16_a, s16_b;
   logic        s16_cin;

   assign i16d1.start  = s16_start;  assign i16d1.a  = s16_a;  assign i16d1.b  = s16_b;  assign i16d1.cin  = s16_cin;
   assign i16d2.start  = s16_start;  assign i16d2.a  = s16_a;  assign i16d2.b  = s16_b;  assign i16d2.cin  = s16_cin;
   assign i16d4.start  = s16_start;  assign i16d4.a  = s16_a;  assign i16d4.b  = s16_b;  assign i16d4.cin  = s16_cin;
   assign i16d8.start  = s16_start;  assign i16d8.a  = s16_a;  assign i16d8.b  = s16_b;  assign i16d8.cin  = s16_cin;
   assign i16d16.start = s16_start;  assign i16d16.a = s16_a;  assign i16d16.b = s16_b;  assign i16d16.cin = s16_cin;

   // Stimulus drivers: called on a falling edge, return one falling edge after the accepting edge.
   task automatic go8d1(input logic [7:0] a, input logic [7:0] b, input logic c);
      i8d1.a = a; i8d1.b = b; i8d1.cin = c; i8d1.start = 1'b1;
      @(negedge clk);
      i8d1.start = 1'b0; i8d1.a = 8'hxx; i8d1.b = 8'hxx; i8d1.cin = 1'bx;
   endtask

   task automatic go8d2(input logic [7:0] a, input logic [7:0] b, input logic c);
      i8d2.a = a; i8d2.b = b; i8d2.cin = c; i8d2.start = 1'b1;
      @(negedge clk);
      i8d2.start = 1'b0;
   endtask

   task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic c);
      s16_a = a; s16_b = b; s16_cin = c; s16_start = 1'b1;
      @(negedge clk);
      s16_start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      i8d1.start = 1'b1; i8d1.a = 8'h12; i8d1.b = 8'h34; i8d1.cin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({i8d1.busy, i8d1.done} !== 2'b00) begin
         errors++; $display("FAIL reset_status got busy,done=%b want 00", {i8d1.busy, i8d1.done});
      end
      checks++;
      if ({i8d1.cout, i8d1.ovf, i8d1.sum} !== 10'h000) begin
         errors++; $display("FAIL reset_result got cout,ovf,sum=%h want 000", {i8d1.cout, i8d1.ovf, i8d1.sum});
      end
      checks++;
      if ({i16d4.busy, i16d4.done, i16d4.sum} !== 18'h0) begin
         errors++; $display("FAIL reset_w16 got %h want 0", {i16d4.busy, i16d4.done, i16d4.sum});
      end
      i8d1.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({i8d1.busy, i8d1.done} !== 2'b00) begin
         errors++; $display("FAIL idle_after_reset got busy,done=%b want 00", {i8d1.busy, i8d1.done});
      end
   endtask

   task automatic test_w8d1_basic;
      go8d1(8'hFF, 8'h01, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         checks++;
         if ({i8d1.busy, i8d1.done, i8d1.sum} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL w8d1_run%0d got busy,done,sum=%b,%b,%h want 1,0,00", k, i8d1.busy, i8d1.done, i8d1.sum);
         end
         @(negedge clk);
      end
      checks++;
      if ({i8d1.busy, i8d1.done} !== 2'b01) begin
         errors++; $display("FAIL w8d1_done got busy,done=%b want 01", {i8d1.busy, i8d1.done});
      end
      checks++;
      if ({i8d1.cout, i8d1.ovf, i8d1.sum} !== {2'b10, 8'h00}) begin
         errors++; $display("FAIL w8d1_ff_01 got cout,ovf,sum=%b,%b,%h want 1,0,00", i8d1.cout, i8d1.ovf, i8d1.sum);
      end
      @(negedge clk);
      checks++;
      if ({i8d1.busy, i8d1.done, i8d1.cout, i8d1.sum} !== {3'b001, 8'h00}) begin
         errors++; $display("FAIL w8d1_hold got busy,done,cout,sum=%b,%b,%b,%h want 0,0,1,00", i8d1.busy, i8d1.done, i8d1.cout, i8d1.sum);
      end
   endtask

   task automatic test_overflow;
      go8d1(8'h7F, 8'h01, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== {3'b101, 8'h80}) begin
         errors++; $display("FAIL ovf_7f_01 got done,cout,ovf,sum=%b,%b,%b,%h want 1,0,1,80", i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum);
      end
      @(negedge clk);
      go8d1(8'h80, 8'h80, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== {3'b111, 8'h00}) begin
         errors++; $display("FAIL ovf_80_80 got done,cout,ovf,sum=%b,%b,%b,%h want 1,1,1,00", i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum);
      end
      @(negedge clk);
   endtask

   task automatic test_w16d4;
      go16(16'h1234, 16'h4321, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({i16d4.busy, i16d4.done} !== 2'b10) begin
            errors++; $display("FAIL w16d4_run%0d got busy,done=%b want 10", k, {i16d4.busy, i16d4.done});
         end
         @(negedge clk);
      end
      checks++;
      if ({i16d4.busy, i16d4.done, i16d4.cout, i16d4.ovf, i16d4.sum} !== {4'b0100, 16'h5556}) begin
         errors++; $display("FAIL w16d4_sum got busy,done,cout,ovf,sum=%b,%b,%b,%b,%h want 0,1,0,0,5556",
                            i16d4.busy, i16d4.done, i16d4.cout, i16d4.ovf, i16d4.sum);
      end
      // Let the slowest 16-bit instance drain before the random phase.
      repeat (16) @(negedge clk);
   endtask

   task automatic test_start_ignored;
      go8d2(8'h10, 8'h20, 1'b0);             // now at T1
      @(negedge clk);                         // T2: new request mid-RUN
      i8d2.a = 8'hFF; i8d2.b = 8'hFF; i8d2.cin = 1'b1; i8d2.start = 1'b1;
      @(negedge clk);                         // T3
      i8d2.start = 1'b0;
      checks++;
      if ({i8d2.busy, i8d2.done} !== 2'b10) begin
         errors++; $display("FAIL midrun_busy got busy,done=%b want 10", {i8d2.busy, i8d2.done});
      end
      repeat (2) @(negedge clk);              // T5
      checks++;
      if ({i8d2.done, i8d2.cout, i8d2.ovf, i8d2.sum} !== {3'b100, 8'h30}) begin
         errors++; $display("FAIL midrun_result got done,cout,ovf,sum=%b,%b,%b,%h want 1,0,0,30", i8d2.done, i8d2.cout, i8d2.ovf, i8d2.sum);
      end
   endtask

   task automatic test_back_to_back;
      // Still in the DONE cycle left by test_start_ignored.
      go8d2(8'h7F, 8'h7F, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({i8d2.busy, i8d2.done, i8d2.sum} !== {2'b10, 8'h30}) begin
            errors++; $display("FAIL b2b_run%0d got busy,done,sum=%b,%b,%h want 1,0,30", k, i8d2.busy, i8d2.done, i8d2.sum);
         end
         @(negedge clk);
      end
      checks++;
      if ({i8d2.done, i8d2.cout, i8d2.ovf, i8d2.sum} !== {3'b101, 8'hFF}) begin
         errors++; $display("FAIL b2b_result got done,cout,ovf,sum=%b,%b,%b,%h want 1,0,1,FF", i8d2.done, i8d2.cout, i8d2.ovf, i8d2.sum);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_midrun;
      go8d1(8'h11, 8'h22, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if ({i8d1.done, i8d1.sum} !== {1'b1, 8'h33}) begin
         errors++; $display("FAIL pre_abort got done,sum=%b,%h want 1,33", i8d1.done, i8d1.sum);
      end
      @(negedge clk);
      go8d1(8'h44, 8'h55, 1'b0);              // T1
      repeat (2) @(negedge clk);              // T3: third RUN cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({i8d1.busy, i8d1.done, i8d1.cout, i8d1.sum} !== {3'b000, 8'h00}) begin
         errors++; $display("FAIL abort_state got busy,done,cout,sum=%b,%b,%b,%h want 0,0,0,00", i8d1.busy, i8d1.done, i8d1.cout, i8d1.sum);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (i8d1.done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done%0d got done=%b want 0", k, i8d1.done);
         end
         @(negedge clk);
      end
      go8d1(8'h0F, 8'hF1, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if ({i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum} !== {3'b110, 8'h00}) begin
         errors++; $display("FAIL after_abort got done,cout,ovf,sum=%b,%b,%b,%h want 1,1,0,00", i8d1.done, i8d1.cout, i8d1.ovf, i8d1.sum);
      end
      @(negedge clk);
   endtask

   task automatic test_w1;
      i1d1.a = 1'b1; i1d1.b = 1'b1; i1d1.cin = 1'b0; i1d1.start = 1'b1;
      @(negedge clk);
      i1d1.start = 1'b0;
      checks++;
      if ({i1d1.busy, i1d1.done} !== 2'b10) begin
         errors++; $display("FAIL w1_busy got busy,done=%b want 10", {i1d1.busy, i1d1.done});
      end
      @(negedge clk);
      checks++;
      if ({i1d1.busy, i1d1.done, i1d1.cout, i1d1.ovf, i1d1.sum} !== 5'b01110) begin
         errors++; $display("FAIL w1_result got busy,done,cout,ovf,sum=%b want 01110",
                            {i1d1.busy, i1d1.done, i1d1.cout, i1d1.ovf, i1d1.sum});
      end
      @(negedge clk);
      checks++;
      if (i1d1.done !== 1'b0) begin
         errors++; $display("FAIL w1_done_pulse got done=%b want 0", i1d1.done);
      end
   endtask

   task automatic test_random;
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] full;
      logic [17:0] exp;
      for (int n = 0; n < 1000; n++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rc   = 1'($urandom_range(1, 0));
         full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         exp  = {full[16], (ra[15] == rb[15]) && (full[15] != ra[15]), full[15:0]};
         go16(ra, rb, rc);                   // T1
         @(negedge clk);                     // T2
         if (n < 4) begin
            checks++;
            if ({i16d16.done, i16d1.busy} !== 2'b11) begin
               errors++; $display("FAIL rnd_timing%0d got d16.done,d1.busy=%b want 11", n, {i16d16.done, i16d1.busy});
            end
         end
         repeat (15) @(negedge clk);         // T17: DIGIT=1 instance is in DONE
         checks++;
         if ({i16d1.cout, i16d1.ovf, i16d1.sum} !== exp) begin
            errors++; $display("FAIL rnd_d1 %h+%h+%b got %h want %h", ra, rb, rc, {i16d1.cout, i16d1.ovf, i16d1.sum}, exp);
         end
         checks++;
         if ({i16d2.cout, i16d2.ovf, i16d2.sum} !== exp) begin
            errors++; $display("FAIL rnd_d2 %h+%h+%b got %h want %h", ra, rb, rc, {i16d2.cout, i16d2.ovf, i16d2.sum}, exp);
         end
         checks++;
         if ({i16d4.cout, i16d4.ovf, i16d4.sum} !== exp) begin
            errors++; $display("FAIL rnd_d4 %h+%h+%b got %h want %h", ra, rb, rc, {i16d4.cout, i16d4.ovf, i16d4.sum}, exp);
         end
         checks++;
         if ({i16d8.cout, i16d8.ovf, i16d8.sum} !== exp) begin
            errors++; $display("FAIL rnd_d8 %h+%h+%b got %h want %h", ra, rb, rc, {i16d8.cout, i16d8.ovf, i16d8.sum}, exp);
         end
         checks++;
         if ({i16d16.cout, i16d16.ovf, i16d16.sum} !== exp) begin
            errors++; $display("FAIL rnd_d16 %h+%h+%b got %h want %h", ra, rb, rc, {i16d16.cout, i16d16.ovf, i16d16.sum}, exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      i8d1.start = 1'b0; i8d1.a = '0; i8d1.b = '0; i8d1.cin = 1'b0;
      i8d2.start = 1'b0; i8d2.a = '0; i8d2.b = '0; i8d2.cin = 1'b0;
      i1d1.start = 1'b0; i1d1.a = '0; i1d1.b = '0; i1d1.cin = 1'b0;
      s16_start  = 1'b0; s16_a  = '0; s16_b  = '0; s16_cin  = 1'b0;
      @(negedge clk);

      test_reset();
      test_w8d1_basic();
      test_overflow();
      test_w16d4();
      test_start_ignored();
      test_back_to_back();
      test_rst_midrun();
      test_w1();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
